sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 38 +++
 rtl/sram_arb_idfifo.sv | 52 +++++
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port sram-like arbiter: request bundle, source IDs, FSM states.
// Pure type/constant package; no logic, no latency.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_AW = 32;
  localparam int unsigned SRAM_DW = 32;

  typedef struct packed {
    logic               req;
    logic               wr;
    logic [1:0]         size;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_id_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic sram_req_t pack_req(input logic req, input logic wr, input logic [1:0] size,
                                         input logic [SRAM_AW-1:0] addr,
                                         input logic [SRAM_DW-1:0] wdata);
    sram_req_t r;
    r.req   = req;
    r.wr    = wr;
    r.size  = size;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// In-order 1-bit source-ID FIFO; head visible combinationally, pop/push take effect at the clock edge.
// Push while full is accepted only when a pop happens in the same cycle (slot is reused).
module sram_arb_idfifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-to-one sram-like arbiter (inst/data -> mem), 0-cycle accept, responses routed in order by ID FIFO.
// Backpressure: mem_addr_ok low holds a LOCK grant; full ID FIFO blocks new requests. SRAM_ARBITER_RR_EN enables round-robin tie-break.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic        err_spurious
);

  arb_state_e state_q, state_d;
  src_id_e    lock_src_q, lock_src_d;
  sram_req_t  lock_req_q, lock_req_d;
  sram_req_t  inst_bus, data_bus, sel_bus;
  src_id_e    grant_src, tie_src, head_id;
  logic       grant_vld, req_c, accept;
  logic       fifo_full, fifo_empty, fifo_dout, pop, eff_full;
  logic       err_q, err_d;

  assign inst_bus = pack_req(inst_req, inst_wr, inst_size, inst_addr, inst_wdata);
  assign data_bus = pack_req(data_req, data_wr, data_size, data_addr, data_wdata);

  // A response popping this cycle frees a slot, so a full FIFO can still take a push.
  assign pop      = mem_data_ok & ~fifo_empty;
  assign eff_full = fifo_full & ~pop;

`ifdef SRAM_ARBITER_RR_EN
  src_id_e rr_last_q, rr_last_d;
  assign tie_src = (rr_last_q == SRC_DATA) ? SRC_INST : SRC_DATA;
  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) rr_last_d = grant_src;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_last_q <= SRC_INST;
    else      rr_last_q <= rr_last_d;
  end
`else
  assign tie_src = SRC_DATA;
`endif

  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    lock_req_d = lock_req_q;
    grant_src  = tie_src;
    grant_vld  = 1'b0;
    sel_bus    = '0;
    req_c      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inst_req && data_req) grant_src = tie_src;
        else if (data_req)        grant_src = SRC_DATA;
        else                      grant_src = SRC_INST;
        grant_vld = rst & ~eff_full & (inst_req | data_req);
        if (grant_vld) sel_bus = (grant_src == SRC_DATA) ? data_bus : inst_bus;
        req_c  = grant_vld & sel_bus.req;
        accept = req_c & mem_addr_ok;
        if (grant_vld && !mem_addr_ok) begin
          state_d    = ST_LOCK;
          lock_src_d = grant_src;
          lock_req_d = sel_bus;
        end
      end
      ST_LOCK: begin
        // Replay the captured request so mem_* cannot move until it is taken.
        grant_src = lock_src_q;
        grant_vld = rst;
        sel_bus   = lock_req_q;
        req_c     = grant_vld & sel_bus.req & ~eff_full;
        accept    = req_c & mem_addr_ok;
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req      = req_c;
  assign mem_wr       = sel_bus.wr;
  assign mem_size     = sel_bus.size;
  assign mem_addr     = sel_bus.addr;
  assign mem_wdata    = sel_bus.wdata;
  assign inst_addr_ok = accept & (grant_src == SRC_INST);
  assign data_addr_ok = accept & (grant_src == SRC_DATA);

  sram_arb_idfifo #(
    .DEPTH(OUTSTANDING)
  ) u_idfifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .din  (grant_src == SRC_DATA),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head_id      = src_id_e'(fifo_dout);
  assign inst_data_ok = pop & (head_id == SRC_INST);
  assign data_data_ok = pop & (head_id == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign err_d        = err_q | (mem_data_ok & fifo_empty);
  assign err_spurious = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lock_src_q <= SRC_INST;
      lock_req_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      lock_req_q <= lock_req_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed vector bench for sram_arbiter: one row per cycle, inputs driven at negedge, outputs sampled 1ns later.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_spurious;

  localparam logic [31:0] IADDR = 32'hbfc0_0000;
  localparam logic [31:0] DADDR = 32'h8000_0010;
  localparam logic [31:0] DWDAT = 32'h1234_5678;

  always #5 clk = ~clk;

  sram_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .err_spurious(err_spurious)
  );

  // src: 0 = no mem_req expected, 1 = inst request on mem_*, 2 = data request on mem_*
  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rdata;
    logic [1:0]  src;
    logic        iaok, daok, idok, ddok, err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input logic ir, input logic dr, input logic aok, input logic dok,
                              input logic [31:0] rd, input logic [1:0] src, input logic iaok,
                              input logic daok, input logic idok, input logic ddok,
                              input logic err);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rd; v.src = src;
    v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic err);
    n_vec++;
    chk1({tag, ".mem_req"}, mem_req, 1'b0);
    chk1({tag, ".inst_addr_ok"}, inst_addr_ok, 1'b0);
    chk1({tag, ".data_addr_ok"}, data_addr_ok, 1'b0);
    chk1({tag, ".inst_data_ok"}, inst_data_ok, 1'b0);
    chk1({tag, ".data_data_ok"}, data_data_ok, 1'b0);
    chk1({tag, ".err_spurious"}, err_spurious, err);
  endtask

  initial begin
    rst = 1'b0;
    inst_wr = 1'b0; inst_size = 2'b10; inst_addr = IADDR; inst_wdata = 32'h0;
    data_wr = 1'b1; data_size = 2'b10; data_addr = DADDR; data_wdata = DWDAT;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    mem_rdata = 32'h0;

    // inst read, response two cycles later
    add(1,0,1,0, 32'h0,         1, 1,0,0,0, 0);
    add(0,0,1,0, 32'h0,         0, 0,0,0,0, 0);
    add(0,0,1,1, 32'h3c010001,  0, 0,0,1,0, 0);
    // simultaneous: data first, inst next; responses in that order
    add(1,1,1,0, 32'h0,         2, 0,1,0,0, 0);
    add(1,0,1,0, 32'h0,         1, 1,0,0,0, 0);
    add(0,0,0,1, 32'hd0d00001,  0, 0,0,0,1, 0);
    add(0,0,0,1, 32'h11110002,  0, 0,0,1,0, 0);
    // data store stalled 3 cycles, grant must stay on data
    add(0,1,0,0, 32'h0,         2, 0,0,0,0, 0);
    add(1,1,0,0, 32'h0,         2, 0,0,0,0, 0);
    add(1,1,0,0, 32'h0,         2, 0,0,0,0, 0);
    add(1,1,1,0, 32'h0,         2, 0,1,0,0, 0);
    add(1,0,1,0, 32'h0,         1, 1,0,0,0, 0);
    add(0,0,0,1, 32'hd0d00003,  0, 0,0,0,1, 0);
    add(0,0,0,1, 32'h11110004,  0, 0,0,1,0, 0);
    // fill to 4 outstanding, blocked, then push+pop in one cycle
    for (int k = 0; k < 4; k++) add(1,0,1,0, 32'h0, 1, 1,0,0,0, 0);
    add(1,0,1,0, 32'h0,         0, 0,0,0,0, 0);
    add(1,0,1,1, 32'haaaa0001,  1, 1,0,1,0, 0);
    add(1,0,1,0, 32'h0,         0, 0,0,0,0, 0);
    for (int k = 0; k < 4; k++) add(0,0,0,1, 32'hbbbb0000 + k, 0, 0,0,1,0, 0);
    // spurious response, sticky flag
    add(0,0,0,1, 32'hdeadbeef,  0, 0,0,0,0, 0);
    add(0,0,0,0, 32'h0,         0, 0,0,0,0, 1);
    add(1,0,1,0, 32'h0,         1, 1,0,0,0, 1);
    add(0,0,0,1, 32'hcccc0001,  0, 0,0,1,0, 1);
    // four back-to-back ties, then drain two responses
`ifdef SRAM_ARBITER_RR_EN
    add(1,1,1,0, 32'h0,         2, 0,1,0,0, 1);
    add(1,1,1,0, 32'h0,         1, 1,0,0,0, 1);
    add(1,1,1,0, 32'h0,         2, 0,1,0,0, 1);
    add(1,1,1,0, 32'h0,         1, 1,0,0,0, 1);
    add(0,0,0,1, 32'he0000001,  0, 0,0,0,1, 1);
    add(0,0,0,1, 32'he0000002,  0, 0,0,1,0, 1);
`else
    for (int k = 0; k < 4; k++) add(1,1,1,0, 32'h0, 2, 0,1,0,0, 1);
    add(0,0,0,1, 32'he0000001,  0, 0,0,0,1, 1);
    add(0,0,0,1, 32'he0000002,  0, 0,0,0,1, 1);
`endif

    // outputs quiet while held in reset with every input active
    #12;
    chk_quiet("reset", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      inst_req    = tbl[i].ir;
      data_req    = tbl[i].dr;
      mem_addr_ok = tbl[i].aok;
      mem_data_ok = tbl[i].dok;
      mem_rdata   = tbl[i].rdata;
      #1;
      n_vec++;
      chk1($sformatf("v%0d.mem_req", i), mem_req, tbl[i].src != 2'd0);
      if (tbl[i].src == 2'd1) begin
        chk32($sformatf("v%0d.mem_addr", i), mem_addr, IADDR);
        chk32($sformatf("v%0d.mem_wdata", i), mem_wdata, 32'h0);
        chk1($sformatf("v%0d.mem_wr", i), mem_wr, 1'b0);
      end else if (tbl[i].src == 2'd2) begin
        chk32($sformatf("v%0d.mem_addr", i), mem_addr, DADDR);
        chk32($sformatf("v%0d.mem_wdata", i), mem_wdata, DWDAT);
        chk1($sformatf("v%0d.mem_wr", i), mem_wr, 1'b1);
      end
      if (tbl[i].src != 2'd0)
        chk32($sformatf("v%0d.mem_size", i), {30'h0, mem_size}, 32'h2);
      chk1($sformatf("v%0d.inst_addr_ok", i), inst_addr_ok, tbl[i].iaok);
      chk1($sformatf("v%0d.data_addr_ok", i), data_addr_ok, tbl[i].daok);
      chk1($sformatf("v%0d.inst_data_ok", i), inst_data_ok, tbl[i].idok);
      chk1($sformatf("v%0d.data_data_ok", i), data_data_ok, tbl[i].ddok);
      chk1($sformatf("v%0d.err_spurious", i), err_spurious, tbl[i].err);
      chk32($sformatf("v%0d.inst_rdata", i), inst_rdata, tbl[i].rdata);
      chk32($sformatf("v%0d.data_rdata", i), data_rdata, tbl[i].rdata);
    end

    // reset with two IDs outstanding: everything drops at once
    @(negedge clk);
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_quiet("midrst", 1'b0);
    // a response for a discarded ID is spurious after release
    @(negedge clk);
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk_quiet("postrst", 1'b0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    chk_quiet("postrst_err", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
